// File: rtl/vic_frame_capture_if.sv
// Framebuffer write-request bus: address + packed byte with valid/ready.
// Latency: n/a (signal bundle only).
// Backpressure: the master holds wr_addr/wr_data stable while wr_valid & !wr_ready.
interface vic_frame_capture_if #(
    parameter int ADDR_W = 17
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ready;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vic_frame_capture.sv
// VIC-II capture: crops a visible window, packs two pixels per byte, queues framebuffer writes.
// Latency: byte is valid one clk after the odd pixel's pix_en (FIFO empty).
// Backpressure: FIFO absorbs stalls; a push into a full FIFO without a pop is dropped and flagged.
//
// Ports: clk/rst (async active-low); i_pix_en/i_color/i_hsync/i_vsync video input;
//        wr (master) write-request bus; o_locked, o_overflow, o_frame_cnt, o_frame_done status.

// Generic first-word-fall-through FIFO. Accepts a push when full if a pop happens the same clk.
module vic_frame_capture_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_acc,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             pop_rdy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, pop;

    always_comb begin
        full     = (cnt_q == (PTR_W+1)'(DEPTH));
        pop_vld  = (cnt_q != '0);
        pop      = pop_vld & pop_rdy;
        push_acc = push_vld & (!full | pop);
        // Gate with valid so the idle bus reads as zero rather than stale RAM.
        pop_dat  = pop_vld ? mem_q[rd_ptr_q] : '0;
        wr_ptr_d = push_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_acc && !pop) cnt_d = cnt_q + (PTR_W+1)'(1);
        if (!push_acc && pop) cnt_d = cnt_q - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= push_dat;
    end
endmodule

module vic_frame_capture #(
    parameter logic [8:0] H_START    = 9'd100,
    parameter logic [8:0] H_WIDTH    = 9'd384,
    parameter logic [8:0] V_START    = 9'd16,
    parameter logic [8:0] V_HEIGHT   = 9'd272,
    parameter int         ADDR_W     = 17,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_pix_en,
    input  logic [3:0]             i_color,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    vic_frame_capture_if.master    wr,
    output logic                   o_locked,
    output logic                   o_overflow,
    output logic [7:0]             o_frame_cnt,
    output logic                   o_frame_done
);
    localparam int               MAX_ADDR_I = int'(H_WIDTH) * int'(V_HEIGHT) / 2 - 1;
    localparam logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(MAX_ADDR_I);
    localparam logic [9:0]       H_END      = {1'b0, H_START} + {1'b0, H_WIDTH};
    localparam logic [9:0]       V_END      = {1'b0, V_START} + {1'b0, V_HEIGHT};

    logic [8:0]        h_q, h_d, v_q, v_d;
    logic [3:0]        hi_q, hi_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              locked_q, locked_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              done_q, done_d;

    logic [8:0]        h_cur, v_cur;
    logic              vs_smp, in_win, capture, h_odd;
    logic              push_vld, push_acc;
    logic [ADDR_W+7:0] push_dat, pop_dat;

    always_comb begin
        vs_smp = i_pix_en & i_hsync & i_vsync;

        // Position of the current sample; both counters saturate at 511.
        h_cur = i_hsync ? 9'd0 : ((h_q == 9'd511) ? h_q : h_q + 9'd1);
        if (i_hsync && i_vsync) v_cur = 9'd0;
        else if (i_hsync)       v_cur = (v_q == 9'd511) ? v_q : v_q + 9'd1;
        else                    v_cur = v_q;

        in_win  = (h_cur >= H_START) && ({1'b0, h_cur} < H_END) &&
                  (v_cur >= V_START) && ({1'b0, v_cur} < V_END);
        // Only parity of (h - H_START) matters for even/odd.
        h_odd   = h_cur[0] ^ H_START[0];
        capture = i_pix_en & (locked_q | vs_smp) & in_win;

        h_d      = i_pix_en ? h_cur : h_q;
        v_d      = i_pix_en ? v_cur : v_q;
        hi_d     = hi_q;
        pend_d   = pend_q;
        addr_d   = addr_q;
        locked_d = locked_q | vs_smp;
        fcnt_d   = (vs_smp && locked_q) ? fcnt_q + 8'd1 : fcnt_q;
        push_vld = 1'b0;
        push_dat = {addr_q, hi_q, i_color};

        if (i_pix_en && i_hsync) pend_d = 1'b0;
        if (vs_smp)              addr_d = '0;

        if (capture && !h_odd) begin
            hi_d   = i_color;
            pend_d = 1'b1;
        end else if (capture && h_odd && pend_q) begin
            push_vld = 1'b1;
            pend_d   = 1'b0;
            // Counts attempts, not acceptances, so addresses stay positional after drops.
            addr_d   = addr_q + ADDR_W'(1);
        end

        ovf_d = ovf_q;
        if (vs_smp)                ovf_d = 1'b0;
        if (push_vld && !push_acc) ovf_d = 1'b1;

        done_d = wr.wr_valid & wr.wr_ready & (wr.wr_addr == MAX_ADDR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q      <= '0;
            v_q      <= '0;
            hi_q     <= '0;
            pend_q   <= 1'b0;
            addr_q   <= '0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
            fcnt_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hi_q     <= hi_d;
            pend_q   <= pend_d;
            addr_q   <= addr_d;
            locked_q <= locked_d;
            ovf_q    <= ovf_d;
            fcnt_q   <= fcnt_d;
            done_q   <= done_d;
        end
    end

    vic_frame_capture_fifo #(
        .WIDTH (ADDR_W + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .push_acc (push_acc),
        .pop_vld  (wr.wr_valid),
        .pop_dat  (pop_dat),
        .pop_rdy  (wr.wr_ready)
    );

    assign wr.wr_addr   = pop_dat[ADDR_W+7:8];
    assign wr.wr_data   = pop_dat[7:0];
    assign o_locked     = locked_q;
    assign o_overflow   = ovf_q;
    assign o_frame_cnt  = fcnt_q;
    assign o_frame_done = done_q;
endmodule

// File: doc/vic_frame_capture.md
Name: vic_frame_capture

Overview:
- Receiving end of the VIC-II video output stream: samples the 4-bit colour index plus hsync/vsync pulses at the 8 MHz pixel strobe.
- Crops a fixed visible window and packs two pixels per byte.
- Emits framebuffer write requests (address + byte) through a small FIFO with valid/ready handshake.
- Sits between the video generator and the scan-converter/framebuffer RAM.

Parameters:
- H_START, 9'd100, first captured pixel index after hsync sample (hsync sample is h=0)
- H_WIDTH, 9'd384, captured pixels per line; must be even
- V_START, 9'd16, first captured line after vsync line (vsync line is v=0)
- V_HEIGHT, 9'd272, captured lines per frame
- ADDR_W, 17, framebuffer byte address width
- FIFO_DEPTH, 8, write FIFO entries; power of two

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- i_pix_en  in  1  8 MHz pixel strobe; all video inputs are qualified by it
- i_color  in  4  colour index of current sample
- i_hsync  in  1  line-start pulse, one pix_en sample wide
- i_vsync  in  1  frame-start pulse; only meaningful together with i_hsync
- o_wr_valid  out  1  write request pending
- o_wr_addr  out  ADDR_W  byte address
- o_wr_data  out  8  packed pixels: {even pixel, odd pixel}
- i_wr_ready  in  1  sink accepts when high together with o_wr_valid
- o_locked  out  1  first vsync seen since reset
- o_overflow  out  1  sticky: byte dropped this frame
- o_frame_cnt  out  8  vsyncs seen while locked, wraps 255->0
- o_frame_done  out  1  one-clk pulse when the last byte of the window is accepted

Behaviour:
- Reset values (rst=0, immediate): o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_locked=0, o_overflow=0, o_frame_cnt=0, o_frame_done=0. Counters, packer and FIFO are cleared.
- Reset mid-frame discards all FIFO contents. Capture resumes only after the next vsync.
- Position counters, updated only when i_pix_en=1:
  - Sample with i_hsync=1 has h=0. Otherwise h=h_prev+1, saturating at 511.
  - Sample with i_hsync&i_vsync has v=0. A sample with i_hsync only has v=v_prev+1, saturating at 511.
  - i_vsync without i_hsync is ignored.
- Lock: o_locked rises on the first vsync sample and stays high until reset. Nothing is captured while unlocked.
- In-window: h in [H_START, H_START+H_WIDTH) and v in [V_START, V_START+V_HEIGHT), both unsigned 9-bit compares.
- Packing:
  - Even (h-H_START) pixel is latched as the high nibble.
  - The following odd pixel forms the low nibble and pushes {addr, byte} into the FIFO.
  - A pending high nibble is discarded on hsync.
- Address:
  - Byte address counter resets to 0 on each vsync sample.
  - It increments by 1 per push attempt, including dropped ones, so addresses stay positional.
  - Max address = H_WIDTH*V_HEIGHT/2 - 1. Width is truncated to ADDR_W.
- FIFO:
  - First-word-fall-through: o_wr_valid = not empty.
  - o_wr_addr/o_wr_data are held stable while o_wr_valid & !i_wr_ready.
  - Pop on o_wr_valid & i_wr_ready.
  - Push and pop in the same clk are both performed; if full, the push is accepted because the pop frees a slot.
  - Push while full without a pop drops the byte and sets o_overflow.
- o_overflow clears on the vsync sample. If a drop coincides with that sample, the flag is set (set wins).
- o_frame_cnt increments on each vsync sample while o_locked is already 1. The locking vsync is not counted.
- o_frame_done pulses the clk after the byte with max address is accepted. It does not pulse if that byte was dropped.
- Latency: the byte appears on o_wr_valid the clk after the odd pixel's pix_en, when the FIFO was empty.
- i_pix_en=0: no counter, packer or push activity. FIFO pops continue.

Test Plan:
- Params H_START=2, H_WIDTH=4, V_START=1, V_HEIGHT=2, ready=1. Feed vsync+hsync, then 2 lines of 8 samples with colours 0..7 per line, i_pix_en every 8th clk -> 4 writes: (0,0x23),(1,0x45),(2,0x23),(3,0x45). o_frame_done pulses once. o_locked=1, o_frame_cnt=0.
- Same stream without an initial vsync -> no writes, o_locked=0.
- Two frames -> o_frame_cnt=1 after the second vsync. Addresses restart at 0.
- FIFO_DEPTH=2, ready=0 for whole frame -> 2 entries held with stable addr/data (0,0x23),(1,0x45); o_overflow=1. Next vsync clears o_overflow. Releasing ready drains exactly those 2.
- hsync arriving after an even in-window pixel (line shortened) -> no partial byte; next line starts at the correct address.
- rst pulled low mid-frame with 3 FIFO entries -> o_wr_valid=0 immediately. After release, no writes until the next vsync, then address 0.
